// File: rtl/morse_pkg.sv
// Shared Morse definitions: FSM states, letter codes, timing defaults, pattern table.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2
    } state_t;

    typedef logic [2:0] letter_t;

    // Letter codes equal the encoder's switch select values.
    localparam letter_t LETTER_A = 3'd0;
    localparam letter_t LETTER_B = 3'd1;
    localparam letter_t LETTER_C = 3'd2;
    localparam letter_t LETTER_D = 3'd3;
    localparam letter_t LETTER_E = 3'd4;
    localparam letter_t LETTER_F = 3'd5;
    localparam letter_t LETTER_G = 3'd6;
    localparam letter_t LETTER_H = 3'd7;

    localparam int DEF_DOT_LEN    = 1;
    localparam int DEF_DASH_LEN   = 3;
    localparam int DEF_LETTER_GAP = 3;
    localparam int DEF_RUN_W      = 3;
    localparam int DEF_MAX_ELEM   = 4;

    localparam int NUM_LETTERS = 8;

    // Indexed by letter code. Pattern bits: 1 = dash, 0 = dot, first element
    // in the MSB of the used bits.
    localparam int CODE_LEN [NUM_LETTERS] = '{2, 4, 4, 3, 1, 4, 3, 4};
    localparam int CODE_PAT [NUM_LETTERS] = '{1, 8, 10, 4, 0, 2, 6, 0};

endpackage

// File: rtl/morse_decoder_if.sv
// Decoder stream/result bundle: sampled keyed input plus decoded letter outputs.
// Latency: n/a (wiring only).
// Backpressure: none; result pulses are fire-and-forget.
interface morse_decoder_if;
    import morse_pkg::*;

    logic    tick;
    logic    morse_in;
    letter_t letter;
    logic    letter_valid;
    logic    letter_error;
    logic    busy;

    modport master (
        output tick, morse_in,
        input  letter, letter_valid, letter_error, busy
    );

    modport slave (
        input  tick, morse_in,
        output letter, letter_valid, letter_error, busy
    );
endinterface

// File: rtl/morse_lookup.sv
// Combinational (len, pat) -> {hit, letter} table for letters A..H.
// Latency: 0 cycles, purely combinational.
// Backpressure: none.
module morse_lookup
    import morse_pkg::*;
#(
    parameter  int MAX_ELEM = DEF_MAX_ELEM,
    localparam int LEN_W    = $clog2(MAX_ELEM + 1)
) (
    input  logic [LEN_W-1:0]    len,
    input  logic [MAX_ELEM-1:0] pat,
    output logic                hit,
    output letter_t             letter
);

    logic [MAX_ELEM-1:0] used;

    // Mask off bits above the recorded length, then scan the table for a match.
    always_comb begin
        used   = pat & MAX_ELEM'((1 << len) - 1);
        hit    = 1'b0;
        letter = LETTER_A;
        for (int i = 0; i < NUM_LETTERS; i++) begin
            if (int'(len) == CODE_LEN[i] && int'(used) == CODE_PAT[i]) begin
                hit    = 1'b1;
                letter = letter_t'(i);
            end
        end
    end

endmodule

// File: rtl/morse_decoder.sv
// Serial Morse receiver: run-length classifies marks/spaces per tick, emits letter A..H.
// Latency: 1 clk from the letter-terminating tick to letter_valid/letter_error.
// Backpressure: none; input is sampled on tick and result pulses last one cycle.
module morse_decoder
    import morse_pkg::*;
#(
    parameter int DOT_LEN    = DEF_DOT_LEN,
    parameter int DASH_LEN   = DEF_DASH_LEN,
    parameter int LETTER_GAP = DEF_LETTER_GAP,
    parameter int RUN_W      = DEF_RUN_W,
    parameter int MAX_ELEM   = DEF_MAX_ELEM
) (
    input logic            clk,
    input logic            resetn,
    morse_decoder_if.slave bus
);

    localparam int LEN_W = $clog2(MAX_ELEM + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = '1;
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

    state_t              state;
    logic [RUN_W-1:0]    run;
    logic [LEN_W-1:0]    len;
    logic [MAX_ELEM-1:0] pat;
    logic                err_pend;

    letter_t             letter_q;
    logic                valid_q;
    logic                error_q;
    logic                busy_q;

    logic                lk_hit;
    letter_t             lk_letter;

    morse_lookup #(.MAX_ELEM(MAX_ELEM)) u_lookup (
        .len    (len),
        .pat    (pat),
        .hit    (lk_hit),
        .letter (lk_letter)
    );

    // Receiver FSM: tracks the current run, records elements, resolves the letter at the gap.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            run      <= '0;
            len      <= '0;
            pat      <= '0;
            err_pend <= 1'b0;
            letter_q <= LETTER_A;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            error_q <= 1'b0;
            if (bus.tick) begin
                case (state)
                    IDLE: begin
                        if (bus.morse_in) begin
                            state  <= MARK;
                            run    <= RUN_ONE;
                            busy_q <= 1'b1;
                        end
                    end
                    MARK: begin
                        if (bus.morse_in) begin
                            if (run != RUN_MAX) run <= run + RUN_ONE;
                        end else begin
                            // A full element buffer rejects the letter but keeps what was recorded.
                            if (len == LEN_W'(MAX_ELEM)) begin
                                err_pend <= 1'b1;
                            end else if (run == RUN_W'(DOT_LEN)) begin
                                pat <= {pat[MAX_ELEM-2:0], 1'b0};
                                len <= len + LEN_W'(1);
                            end else if (run == RUN_W'(DASH_LEN)) begin
                                pat <= {pat[MAX_ELEM-2:0], 1'b1};
                                len <= len + LEN_W'(1);
                            end else begin
                                err_pend <= 1'b1;
                            end
                            state <= SPACE;
                            run   <= RUN_ONE;
                        end
                    end
                    SPACE: begin
                        if (!bus.morse_in) begin
                            if (run == RUN_W'(LETTER_GAP - 1)) begin
                                if (lk_hit && !err_pend) begin
                                    letter_q <= lk_letter;
                                    valid_q  <= 1'b1;
                                end else begin
                                    error_q  <= 1'b1;
                                end
                                state    <= IDLE;
                                run      <= '0;
                                len      <= '0;
                                pat      <= '0;
                                err_pend <= 1'b0;
                                busy_q   <= 1'b0;
                            end else if (run != RUN_MAX) begin
                                run <= run + RUN_ONE;
                            end
                        end else begin
                            // Only a single-unit gap is legal between elements.
                            if (run != RUN_ONE) err_pend <= 1'b1;
                            state <= MARK;
                            run   <= RUN_ONE;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.letter       = letter_q;
    assign bus.letter_valid = valid_q;
    assign bus.letter_error = error_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_morse_decoder.sv
// Bench for morse_decoder: directed and random keyed streams against a run-parsing model.
// Latency: outputs compared 1 ns after every clk edge that follows a driven cycle.
// Backpressure: n/a.
module tb_morse_decoder;

    localparam int GAP = 3;

    logic clk;
    logic resetn;

    morse_decoder_if bus ();

    morse_decoder dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_checks;
    int    n_errs;
    string phase;

    // Reference model state.
    string      tbl [8] = '{"01", "1000", "1010", "100", "0", "0010", "110", "0000"};
    bit         cur [$];
    bit         active;
    logic [2:0] exp_letter;
    bit         exp_valid;
    bit         exp_error;
    bit         exp_busy;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
        n_checks++;
        if (got !== want) begin
            n_errs++;
            $display("FAIL %s/%s got=%0d want=%0d", phase, tag, got, want);
        end
    endtask

    // Splits the letter's samples into mark and space runs and decides the outcome.
    function automatic void model_decode();
        string el;
        bit    err;
        int    i;
        int    n;
        int    body;
        int    found;
        el    = "";
        err   = 1'b0;
        i     = 0;
        found = -1;
        body  = cur.size() - GAP;
        while (i < body) begin
            n = 0;
            while (i < body && cur[i] == 1'b1) begin n++; i++; end
            if (n == 1)      el = {el, "0"};
            else if (n == 3) el = {el, "1"};
            else             err = 1'b1;
            n = 0;
            while (i < body && cur[i] == 1'b0) begin n++; i++; end
            if (n > 1) err = 1'b1;
        end
        if (el.len() > 4) err = 1'b1;
        for (int k = 0; k < 8; k++) if (tbl[k] == el) found = k;
        if (!err && found >= 0) begin
            exp_valid  = 1'b1;
            exp_letter = 3'(found);
        end else begin
            exp_error = 1'b1;
        end
    endfunction

    function automatic void model_tick(input bit b);
        int tz;
        exp_valid = 1'b0;
        exp_error = 1'b0;
        if (!active) begin
            if (b) begin
                active = 1'b1;
                cur.delete();
                cur.push_back(1'b1);
            end
        end else begin
            cur.push_back(b);
            tz = 0;
            for (int i = cur.size() - 1; i >= 0; i--) begin
                if (cur[i] != 1'b0) break;
                tz++;
            end
            if (tz == GAP) begin
                model_decode();
                active = 1'b0;
            end
        end
        exp_busy = active;
    endfunction

    function automatic void model_reset();
        active     = 1'b0;
        cur.delete();
        exp_letter = 3'd0;
        exp_valid  = 1'b0;
        exp_error  = 1'b0;
        exp_busy   = 1'b0;
    endfunction

    task automatic step(input bit t, input bit b);
        @(negedge clk);
        bus.tick     = t;
        bus.morse_in = b;
        @(posedge clk);
        if (t) model_tick(b);
        else begin
            exp_valid = 1'b0;
            exp_error = 1'b0;
        end
        #1;
        chk("valid",  bus.letter_valid, exp_valid);
        chk("error",  bus.letter_error, exp_error);
        chk("letter", bus.letter,       exp_letter);
        chk("busy",   bus.busy,         exp_busy);
    endtask

    // One tick per character, followed by sp idle clocks with the level held.
    task automatic send(input string s, input int sp);
        bit b;
        for (int i = 0; i < s.len(); i++) begin
            b = (s.getc(i) == 8'h31);
            step(1'b1, b);
            for (int j = 0; j < sp; j++) step(1'b0, b);
        end
    endtask

    function automatic string enc(input int code);
        string s;
        string p;
        s = "";
        p = tbl[code];
        for (int i = 0; i < p.len(); i++) begin
            if (i > 0) s = {s, "0"};
            s = {s, (p.getc(i) == 8'h31) ? "111" : "1"};
        end
        return {s, "000"};
    endfunction

    initial begin
        string s;
        int    k;
        n_checks     = 0;
        n_errs       = 0;
        phase        = "reset";
        bus.tick     = 1'b0;
        bus.morse_in = 1'b0;
        resetn       = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("letter", bus.letter,       3'd0);
        chk("valid",  bus.letter_valid, 1'b0);
        chk("error",  bus.letter_error, 1'b0);
        chk("busy",   bus.busy,         1'b0);
        @(negedge clk);
        resetn = 1'b1;

        phase = "t1_A";
        send("10111000", 0);
        chk("t1_letter", bus.letter, 3'd0);
        step(1'b0, 1'b0);
        chk("t1_busy", bus.busy, 1'b0);

        phase = "t2_CH";
        send("11101011101000", 0);
        send("1010101000", 0);
        chk("t2_letter", bus.letter, 3'd7);

        phase = "t3_bad";
        send("11000", 0);
        send("101010101000", 0);
        send("1001000", 0);
        chk("t3_letter", bus.letter, 3'd7);

        phase = "t4_slow";
        send("1000", 3);
        chk("t4_letter", bus.letter, 3'd4);

        phase = "t5_rst";
        send("101", 0);
        @(negedge clk);
        bus.tick = 1'b0;
        #2 resetn = 1'b0;
        model_reset();
        #1;
        chk("rst_letter", bus.letter, 3'd0);
        chk("rst_busy",   bus.busy,   1'b0);
        chk("rst_valid",  bus.letter_valid, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        send("1110101000", 0);
        chk("t5_letter", bus.letter, 3'd3);

        phase = "t6_AG";
        send({enc(0), enc(6)}, 0);
        chk("t6_letter", bus.letter, 3'd6);

        phase = "rand";
        for (int it = 0; it < 150; it++) begin
            case ($urandom_range(0, 3))
                0, 1: begin
                    s = enc($urandom_range(0, 7));
                    for (int z = $urandom_range(0, 2); z > 0; z--) s = {s, "0"};
                end
                2: begin
                    s = "";
                    for (int n = $urandom_range(1, 12); n > 0; n--)
                        s = {s, ($urandom_range(0, 1) != 0) ? "1" : "0"};
                    s = {s, "000"};
                end
                default: begin
                    s = enc($urandom_range(0, 7));
                    k = $urandom_range(0, s.len() - 1);
                    s.putc(k, (s.getc(k) == 8'h31) ? 8'h30 : 8'h31);
                end
            endcase
            send(s, $urandom_range(0, 2));
        end
        send("000", 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
